// File: rtl/wavelet_pkg.sv
// -----------------------------------------------------------------------------
// wavelet_pkg
// Shared definitions for the DAUB-4 lifting wavelet blocks (forward and
// inverse). Holds the datapath width, the Q16.16 fixed-point format and the
// lifting / scaling constants, plus the output-buffer state type used by the
// inverse transform.
// -----------------------------------------------------------------------------
package wavelet_pkg;

  // Datapath width (signed two's complement) and number of fractional bits.
  localparam int SIZE = 32;
  localparam int FRAC = 16;

  // Lifting and scaling constants, Q16.16.
  localparam logic [31:0] ALPHA = 32'hFFFE_4498;  // predict step
  localparam logic [31:0] BETA  = 32'h0000_6EDA;  // update step, d1[n] tap
  localparam logic [31:0] GAMMA = 32'hFFFF_EEDA;  // update step, d1[n-1] tap
  localparam logic [31:0] OMEGA = 32'h0001_EE8E;  // low-band scale (1/nu)
  localparam logic [31:0] NU    = 32'h0000_8484;  // high-band scale (1/omega)

  // Output buffer of the inverse transform: empty, presenting the even
  // sample, or presenting the odd sample.
  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_EVEN  = 2'd1,
    BUF_ODD   = 2'd2
  } buf_state_t;

endpackage : wavelet_pkg

// File: rtl/q16_mult.sv
// -----------------------------------------------------------------------------
// q16_mult
// Combinational signed fixed-point multiply. Forms the full 2*SIZE-bit signed
// product and returns bits [FRAC+SIZE-1:FRAC], i.e. an arithmetic right shift
// by FRAC, which truncates toward minus infinity.
//
// Ports:
//   a, b : SIZE-bit signed operands (Qxx.FRAC)
//   p    : SIZE-bit signed result   (Qxx.FRAC)
// -----------------------------------------------------------------------------
module q16_mult #(
  parameter int SIZE = wavelet_pkg::SIZE,
  parameter int FRAC = wavelet_pkg::FRAC
) (
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  output logic [SIZE-1:0] p
);

  logic signed [2*SIZE-1:0] a_ext;
  logic signed [2*SIZE-1:0] b_ext;
  logic signed [2*SIZE-1:0] prod;

  // Sign-extend explicitly so the product is the exact signed product.
  assign a_ext = {{SIZE{a[SIZE-1]}}, a};
  assign b_ext = {{SIZE{b[SIZE-1]}}, b};
  assign prod  = a_ext * b_ext;

  // Arithmetic shift keeps the sign, so dropped fraction bits round down.
  assign p = SIZE'(prod >>> FRAC);

endmodule : q16_mult

// File: rtl/inverse_transform.sv
// -----------------------------------------------------------------------------
// inverse_transform
// Single-level inverse DAUB-4 lifting DWT. Accepts one (L, H) coefficient pair
// per handshake and emits the reconstructed time samples interleaved: e[n]
// first, then o[n].
//
//   s1    = nu * L            d2   = omega * H
//   d1[n] = d2 - s1[n-1]
//   e[n]  = s1 - beta * d1[n] - gamma * d1[n-1]
//   o[n]  = d1[n] - alpha * e[n]
//
// Pipeline: P1 scale multiplies, P2 d1, P3 e, P4 o, then the output buffer.
// Every stage advances together on 'en'; the buffer is the only back-pressure
// point, so a held output freezes the whole pipe.
//
// Ports:
//   clk        rising-edge clock
//   resetn     asynchronous active-low reset
//   in_valid   L_in / H_in / sof valid
//   in_ready   pair accepted this cycle when in_valid is high
//   L_in       low-band coefficient  (signed Q16.16)
//   H_in       high-band coefficient (signed Q16.16)
//   sof        start of frame: pair uses zero lifting history
//   out_valid  x_out valid
//   out_ready  sink accepts x_out
//   x_out      reconstructed sample, e[n] then o[n]
// -----------------------------------------------------------------------------
module inverse_transform #(
  parameter int SIZE = wavelet_pkg::SIZE,
  parameter int FRAC = wavelet_pkg::FRAC
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [SIZE-1:0] L_in,
  input  logic [SIZE-1:0] H_in,
  input  logic            sof,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SIZE-1:0] x_out
);

  import wavelet_pkg::ALPHA;
  import wavelet_pkg::BETA;
  import wavelet_pkg::GAMMA;
  import wavelet_pkg::OMEGA;
  import wavelet_pkg::NU;
  import wavelet_pkg::buf_state_t;
  import wavelet_pkg::BUF_EMPTY;
  import wavelet_pkg::BUF_EVEN;
  import wavelet_pkg::BUF_ODD;

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  buf_state_t      state;
  logic            en;

  // P1: scaled coefficients
  logic            v1;
  logic            sof1;
  logic [SIZE-1:0] s1_1;
  logic [SIZE-1:0] d2_1;

  // P2: d1 and the s1 history
  logic            v2;
  logic            sof2;
  logic [SIZE-1:0] s1_2;
  logic [SIZE-1:0] d1_2;
  logic [SIZE-1:0] s1_prev;

  // P3: even sample and the d1 history
  logic            v3;
  logic [SIZE-1:0] e_3;
  logic [SIZE-1:0] d1_3;
  logic [SIZE-1:0] d1_prev;

  // P4: finished {e, o} pair
  logic            v4;
  logic [SIZE-1:0] e_4;
  logic [SIZE-1:0] o_4;

  // Output buffer: odd sample waiting behind the presented even sample
  logic [SIZE-1:0] o_buf;

  // Combinational datapath
  logic [SIZE-1:0] s1_in;
  logic [SIZE-1:0] d2_in;
  logic [SIZE-1:0] beta_d1;
  logic [SIZE-1:0] gamma_d1p;
  logic [SIZE-1:0] alpha_e;
  logic [SIZE-1:0] d1_next;
  logic [SIZE-1:0] d1p_eff;
  logic [SIZE-1:0] e_next;
  logic [SIZE-1:0] o_next;

  // ---------------------------------------------------------------------------
  // Global advance: the pipe moves whenever the buffer is empty or is handing
  // over its last (odd) sample this cycle.
  // ---------------------------------------------------------------------------
  assign en       = (state == BUF_EMPTY) || ((state == BUF_ODD) && out_ready);
  assign in_ready = en && resetn;

  // ---------------------------------------------------------------------------
  // Multipliers
  // ---------------------------------------------------------------------------
  q16_mult #(.SIZE(SIZE), .FRAC(FRAC)) u_mul_nu_l (
    .a (SIZE'(NU)),
    .b (L_in),
    .p (s1_in)
  );

  q16_mult #(.SIZE(SIZE), .FRAC(FRAC)) u_mul_omega_h (
    .a (SIZE'(OMEGA)),
    .b (H_in),
    .p (d2_in)
  );

  q16_mult #(.SIZE(SIZE), .FRAC(FRAC)) u_mul_beta_d1 (
    .a (SIZE'(BETA)),
    .b (d1_2),
    .p (beta_d1)
  );

  q16_mult #(.SIZE(SIZE), .FRAC(FRAC)) u_mul_gamma_d1p (
    .a (SIZE'(GAMMA)),
    .b (d1p_eff),
    .p (gamma_d1p)
  );

  q16_mult #(.SIZE(SIZE), .FRAC(FRAC)) u_mul_alpha_e (
    .a (SIZE'(ALPHA)),
    .b (e_3),
    .p (alpha_e)
  );

  // The sof flag travels with its pair, so pairs still in flight ahead of a
  // new frame finish with the old history while the sof pair sees zeros.
  assign d1_next = d2_1 - (sof1 ? '0 : s1_prev);
  assign d1p_eff = sof2 ? '0 : d1_prev;
  assign e_next  = s1_2 - beta_d1 - gamma_d1p;
  assign o_next  = d1_3 - alpha_e;

  // ---------------------------------------------------------------------------
  // Lifting pipeline P1..P4
  // Data and history registers load only with a valid slot, so bubbles pass
  // through without disturbing the lifting history.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      // NOTE: datapath registers are cleared too, not just the valid bits;
      // the history feeds the next frame's arithmetic and x_out must read 0
      // in reset.
      v1      <= 1'b0;
      sof1    <= 1'b0;
      s1_1    <= '0;
      d2_1    <= '0;
      v2      <= 1'b0;
      sof2    <= 1'b0;
      s1_2    <= '0;
      d1_2    <= '0;
      s1_prev <= '0;
      v3      <= 1'b0;
      e_3     <= '0;
      d1_3    <= '0;
      d1_prev <= '0;
      v4      <= 1'b0;
      e_4     <= '0;
      o_4     <= '0;
    end else if (en) begin
      // NOTE: non-blocking assignments so every stage captures the value the
      // previous stage held before this edge, independent of statement order.
      // P1 (in_ready equals en while out of reset, so this is the handshake)
      v1 <= in_valid;
      if (in_valid) begin
        sof1 <= sof;
        s1_1 <= s1_in;
        d2_1 <= d2_in;
      end

      // P2
      v2 <= v1;
      if (v1) begin
        sof2    <= sof1;
        s1_2    <= s1_1;
        d1_2    <= d1_next;
        s1_prev <= s1_1;
      end

      // P3
      v3 <= v2;
      if (v2) begin
        e_3     <= e_next;
        d1_3    <= d1_2;
        d1_prev <= d1_2;
      end

      // P4
      v4 <= v3;
      if (v3) begin
        e_4 <= e_3;
        o_4 <= o_next;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output buffer FSM: presents e, then o, each held until out_ready.
  // A new pair loads only in cycles where en is high (EMPTY, or ODD being
  // taken), which keeps the buffer in step with the P4 register.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= BUF_EMPTY;
      out_valid <= 1'b0;
      x_out     <= '0;
      o_buf     <= '0;
    end else begin
      case (state)
        BUF_EMPTY: begin
          if (v4) begin
            state     <= BUF_EVEN;
            out_valid <= 1'b1;
            x_out     <= e_4;
            o_buf     <= o_4;
          end
        end
        BUF_EVEN: begin
          if (out_ready) begin
            state <= BUF_ODD;
            x_out <= o_buf;
          end
        end
        BUF_ODD: begin
          if (out_ready) begin
            if (v4) begin
              state     <= BUF_EVEN;
              out_valid <= 1'b1;
              x_out     <= e_4;
              o_buf     <= o_4;
            end else begin
              state     <= BUF_EMPTY;
              out_valid <= 1'b0;
            end
          end
        end
        default: begin
          state     <= BUF_EMPTY;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule : inverse_transform

// File: tb/tb_inverse_transform.sv
// -----------------------------------------------------------------------------
// tb_inverse_transform
// Self-checking bench for inverse_transform. A driver issues pairs and pushes
// the expected samples into a scoreboard queue; a monitor pops and compares
// whenever a sample is handed to the sink. Expected samples come from a
// reference model of the inverse lifting equations written with plain 64-bit
// integer arithmetic, or from fixed vectors for the directed cases. Round-trip
// frames are produced by a forward DAUB-4 model in the bench.
// -----------------------------------------------------------------------------
module tb_inverse_transform;

  // Q16.16 constants, kept independent of the design's package.
  localparam logic [31:0] K_ALPHA = 32'hFFFE_4498;
  localparam logic [31:0] K_BETA  = 32'h0000_6EDA;
  localparam logic [31:0] K_GAMMA = 32'hFFFF_EEDA;
  localparam logic [31:0] K_OMEGA = 32'h0001_EE8E;
  localparam logic [31:0] K_NU    = 32'h0000_8484;

  logic        clk       = 1'b0;
  logic        resetn    = 1'b0;
  logic        in_valid  = 1'b0;
  logic        in_ready;
  logic [31:0] L_in      = '0;
  logic [31:0] H_in      = '0;
  logic        sof       = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] x_out;

  inverse_transform #(.SIZE(32), .FRAC(16)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .L_in      (L_in),
    .H_in      (H_in),
    .sof       (sof),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x_out     (x_out)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] exp;
    logic [31:0] orig;
    bit          rt;
  } sb_t;

  sb_t exp_q[$];

  bit   rand_ready  = 1'b0;
  logic ready_force = 1'b1;
  int   last_waits;
  bit   last_ok;

  // Reference model history
  logic [31:0] m_s1p = '0;
  logic [31:0] m_d1p = '0;

  // Round-trip frame buffers
  logic [31:0] fx [64];
  logic [31:0] fl [32];
  logic [31:0] fh [32];

  task automatic check(input string name, input bit ok,
                       input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: actual 0x%08h required 0x%08h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] req);
    check(name, act === req, act, req);
  endtask

  // Signed Q16.16 multiply: exact product, floor-divided by 2^16.
  function automatic logic [31:0] qmul(input logic [31:0] a, input logic [31:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return 32'(p >>> 16);
  endfunction

  // Inverse lifting for one accepted pair, in acceptance order.
  task automatic model_pair(input logic [31:0] l, input logic [31:0] h, input logic s,
                            output logic [31:0] e, output logic [31:0] o);
    logic [31:0] s1, d2, d1;
    if (s) begin
      m_s1p = '0;
      m_d1p = '0;
    end
    s1 = qmul(K_NU, l);
    d2 = qmul(K_OMEGA, h);
    d1 = d2 - m_s1p;
    e  = s1 - qmul(K_BETA, d1) - qmul(K_GAMMA, m_d1p);
    o  = d1 - qmul(K_ALPHA, e);
    m_s1p = s1;
    m_d1p = d1;
  endtask

  // Forward DAUB-4 on fx[] (fresh frame). The predict step on d2 uses a unit
  // coefficient, which is what d1 = d2 - s1[n-1] inverts.
  task automatic forward_frame();
    logic [31:0] s1p, d1p, e, o, d1, s1, d2;
    s1p = '0;
    d1p = '0;
    for (int n = 0; n < 32; n++) begin
      e  = fx[2*n];
      o  = fx[2*n+1];
      d1 = o + qmul(K_ALPHA, e);
      s1 = e + qmul(K_BETA, d1) + qmul(K_GAMMA, d1p);
      d2 = d1 + s1p;
      fl[n] = qmul(K_OMEGA, s1);
      fh[n] = qmul(K_NU, d2);
      s1p = s1;
      d1p = d1;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sink ready: updated shortly after each rising edge so it is stable when
  // the driver and monitor look at the bus.
  // ---------------------------------------------------------------------------
  initial begin : ready_gen
    forever begin
      @(posedge clk);
      #2;
      out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_force;
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor: one comparison per sample handed to the sink.
  // ---------------------------------------------------------------------------
  initial begin : monitor
    sb_t t;
    int  diff;
    forever begin
      @(negedge clk);
      #1;
      if (resetn && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected x_out", 1'b0, x_out, 32'h0);
        end else begin
          t = exp_q.pop_front();
          check_eq("x_out", x_out, t.exp);
          if (t.rt) begin
            diff = $signed(x_out) - $signed(t.orig);
            if (diff < 0) diff = -diff;
            check("round trip error", diff <= 8, x_out, t.orig);
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver helpers. Entered at a falling edge, return at a falling edge.
  // ---------------------------------------------------------------------------
  task automatic drive_pair(input logic [31:0] l, input logic [31:0] h, input logic s);
    int guard;
    guard    = 0;
    L_in     = l;
    H_in     = h;
    sof      = s;
    in_valid = 1'b1;
    #1;
    while (!in_ready && guard < 500) begin
      @(negedge clk);
      #1;
      guard++;
    end
    last_waits = guard;
    last_ok    = in_ready;
    if (!in_ready) begin
      check("in_ready timeout", 1'b0, 32'(in_ready), 32'h1);
      in_valid = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_model(input logic [31:0] l, input logic [31:0] h, input logic s);
    logic [31:0] e, o;
    drive_pair(l, h, s);
    if (last_ok) begin
      model_pair(l, h, s, e, o);
      exp_q.push_back('{exp: e, orig: '0, rt: 1'b0});
      exp_q.push_back('{exp: o, orig: '0, rt: 1'b0});
    end
  endtask

  task automatic send_exp(input logic [31:0] l, input logic [31:0] h, input logic s,
                          input logic [31:0] ee, input logic [31:0] eo);
    logic [31:0] e, o;
    drive_pair(l, h, s);
    if (last_ok) begin
      model_pair(l, h, s, e, o);
      exp_q.push_back('{exp: ee, orig: '0, rt: 1'b0});
      exp_q.push_back('{exp: eo, orig: '0, rt: 1'b0});
    end
  endtask

  task automatic send_rt(input int n, input logic s);
    logic [31:0] e, o;
    drive_pair(fl[n], fh[n], s);
    if (last_ok) begin
      model_pair(fl[n], fh[n], s, e, o);
      exp_q.push_back('{exp: e, orig: fx[2*n],   rt: 1'b1});
      exp_q.push_back('{exp: o, orig: fx[2*n+1], rt: 1'b1});
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    in_valid = 1'b0;
    while ((exp_q.size() != 0 || out_valid) && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    check_eq("drain scoreboard empty", 32'(exp_q.size()), 32'h0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin : stimulus
    int n;
    logic [31:0] held;

    // Reset state
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_eq("reset out_valid", 32'(out_valid), 32'h0);
    check_eq("reset x_out", x_out, 32'h0);
    check_eq("reset in_ready", 32'(in_ready), 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    check_eq("in_ready after release", 32'(in_ready), 32'h1);
    @(negedge clk);

    // Directed vectors and latency
    send_exp(32'h0001_EE8E, 32'h0, 1'b1, 32'h0001_0000, 32'h0001_BB68);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("first out_valid latency", 32'(n), 32'd4);
    send_exp(32'h0, 32'h0, 1'b0, 32'h0000_6EDA, 32'hFFFF_C001);
    send_exp(32'h0001_EE8E, 32'h0, 1'b1, 32'h0001_0000, 32'h0001_BB68);
    drain();

    // Continuous input with the sink always ready: steady-state in_ready 1,0
    for (int i = 0; i < 10; i++) begin
      send_model($urandom, $urandom, 1'b0);
      if (i >= 5) check_eq("in_ready wait cycles", 32'(last_waits), 32'd1);
    end
    drain();

    // Stall while the even sample is presented
    send_exp(32'h0001_EE8E, 32'h0, 1'b1, 32'h0001_0000, 32'h0001_BB68);
    ready_force = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("stall out_valid", 32'(out_valid), 32'h1);
    L_in     = 32'h0;
    H_in     = 32'h0;
    sof      = 1'b0;
    in_valid = 1'b1;
    held     = x_out;
    for (int i = 0; i < 10; i++) begin
      #1;
      check_eq("stall x_out even", x_out, 32'h0001_0000);
      check_eq("stall x_out stable", x_out, held);
      check_eq("stall in_ready", 32'(in_ready), 32'h0);
      @(negedge clk);
    end
    ready_force = 1'b1;
    send_exp(32'h0, 32'h0, 1'b0, 32'h0000_6EDA, 32'hFFFF_C001);
    drain();

    // Reset with pairs in flight
    for (int i = 0; i < 5; i++) send_model($urandom, $urandom, i == 0);
    check_eq("out_valid before reset", 32'(out_valid), 32'h1);
    resetn = 1'b0;
    #1;
    check_eq("out_valid in reset", 32'(out_valid), 32'h0);
    check_eq("x_out in reset", x_out, 32'h0);
    check_eq("in_ready in reset", 32'(in_ready), 32'h0);
    exp_q.delete();
    m_s1p = '0;
    m_d1p = '0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    #1;
    check_eq("in_ready after mid-run reset", 32'(in_ready), 32'h1);
    @(negedge clk);
    send_exp(32'h0001_EE8E, 32'h0, 1'b0, 32'h0001_0000, 32'h0001_BB68);
    drain();

    // Random pairs, random sof, bubbles and random sink back-pressure
    rand_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      send_model($urandom, $urandom, $urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    drain();

    // Round trip through the forward model
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 64; i++) fx[i] = 32'(int'($urandom_range(0, 65536)) - 32768);
      forward_frame();
      for (int i = 0; i < 32; i++) send_rt(i, i == 0);
    end
    drain();
    rand_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, actual running required finished");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_inverse_transform
